pdm_level_sequencer: RTL and testbench
======================================

// Module: pdm_level_sequencer
// PURPOSE
//  Feeds a stored sequence of 5-bit levels to the downstream PDM generator over its write_en/level interface.
//  - Holds an 8-entry level table and issues one write per PWM frame (PERIOD cycles).
//  - Plays the table once or in a loop, and supports stop/mute.
//  - Sits between the tile's io_in config pins and the PDM datapath; one write per frame boundary.
// PARAMETERS
//  DEPTH    8   level table entries
//  AW       3   table address width, clog2(DEPTH)
//  LEVEL_W  5   PDM level width
//  PERIOD   64  clocks per PDM frame (>=2); spacing between pdm_we pulses
//  CNT_W    6   frame counter width, clog2(PERIOD)
// PORTS
//  clk        in   1        system clock, all logic rising-edge
//  reset      in   1        synchronous, active-high
//  cfg_we     in   1        table write strobe
//  cfg_addr   in   AW       table write address
//  cfg_data   in   LEVEL_W  table write data
//  start      in   1        begin playback (pulse)
//  stop       in   1        abort playback (pulse)
//  loop       in   1        1 = wrap to entry 0 after last entry
//  seq_len    in   AW       index of last entry played (entries 0..seq_len)
//  pdm_we     out  1        one-cycle write strobe to PDM generator
//  pdm_level  out  LEVEL_W  level presented with pdm_we, held between writes
//  busy       out  1        high while PLAY (or FADE)
//  step_idx   out  AW       table index currently playing
//  done       out  1        one-cycle pulse on non-loop completion
// BEHAVIOUR
//  - Reset: all outputs 0, table cleared to 0, frame counter 0, state IDLE. Reset mid-play aborts at once with no mute write.
//  - All outputs are registered.
//  - States: IDLE, PLAY (FADE only with the macro).
//  - IDLE -> PLAY on start sampled high at edge N:
//    - At N+1: pdm_we=1, pdm_level=table[0], step_idx=0, busy=1, counter=0.
//    - loop and seq_len are latched at start and held for the whole run.
//  - PLAY: the counter runs 0..PERIOD-1.
//    - Each write happens at counter==0, so step k is written at N+1+k*PERIOD.
//    - At counter==PERIOD-1 with step_idx<seq_len: advance step_idx.
//    - At counter==PERIOD-1 with step_idx==seq_len and loop=1: step_idx -> 0.
//    - At counter==PERIOD-1 with step_idx==seq_len and loop=0: go IDLE; busy=0, done=1 for one cycle; pdm_level holds last value; no write.
//  - Table read: pdm_level takes the table contents as of the edge that issues the write.
//    - A cfg_we to that entry in the same cycle is not seen until the next pass.
//  - cfg_we is accepted in any state and never stalls playback.
//  - stop in PLAY: next cycle pdm_we=1, pdm_level=0 (mute), busy=0, step_idx=0, no done.
//  - stop in IDLE: no effect.
//  - stop and start in the same cycle: stop wins; start is ignored.
//  - start while busy: ignored.
//  - seq_len=0, loop=0: a single write, then done after PERIOD cycles.
// CONFIGURATION
//  - PDM_SEQ_FADE_EN defined: stop in PLAY enters FADE instead of muting.
//    - Next cycle pdm_we=1 with pdm_level-1, then one more decrement write every PERIOD cycles.
//    - Leaves FADE for IDLE (busy=0, no done) the cycle after the write of 0.
//    - If the level is already 0: a single write of 0, then IDLE.
//    - start and stop are ignored in FADE; reset still wins.
//  - Undefined: FADE state is absent; stop mutes immediately as above.
// TESTING
//  - Reset 2 cycles, idle 10 -> pdm_we, pdm_level, busy, done, step_idx all 0 throughout.
//  - Load {08,1A,0F,04}, seq_len=3, loop=0, start at N -> writes 08@N+1, 1A@N+65, 0F@N+129, 04@N+193; done@N+257; busy falls @N+257; level stays 04.
//  - Load {03,05}, seq_len=1, loop=1 -> levels 03,05,03,05 at 64-cycle spacing; step_idx toggles; no done.
//  - Playing entry 1 (1A), stop at N+100 -> N+101 pdm_we=1, level 00, busy 0. With FADE_EN and level 03: writes 02@+1, 01@+65, 00@+129, busy 0 @+130.
//  - start+stop same cycle in IDLE -> nothing. cfg_we entry 2 <- 1F at N+100 -> step 2 writes 1F @N+129.
//  - reset mid-PLAY -> next cycle all outputs 0, no mute write; a later start replays from entry 0 of the cleared table (level 00).

Source files
------------

// File: rtl/pdm_level_sequencer.sv
// Plays an 8-entry table of PDM levels, one pdm_we write per PERIOD-cycle frame.
// Optional macro PDM_SEQ_FADE_EN: stop ramps the level down to 0 instead of muting at once.
module pdm_level_sequencer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int LEVEL_W = 5,
    parameter int PERIOD  = 64,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [LEVEL_W-1:0] cfg_data,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [AW-1:0]      seq_len,
    output logic               pdm_we,
    output logic [LEVEL_W-1:0] pdm_level,
    output logic               busy,
    output logic [AW-1:0]      step_idx,
    output logic               done
);

`ifdef PDM_SEQ_FADE_EN
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FADE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PLAY} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      step_q, step_d;
    logic [AW-1:0]      seq_len_q, seq_len_d;
    logic               loop_q, loop_d;
    logic               pdm_we_q, pdm_we_d;
    logic [LEVEL_W-1:0] pdm_level_q, pdm_level_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEVEL_W-1:0] tab_q [DEPTH];
    logic [LEVEL_W-1:0] tab_d [DEPTH];
    logic [AW-1:0]      next_idx;

    // Table reads use tab_q, so a same-cycle cfg write only shows on the next pass.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        seq_len_d   = seq_len_q;
        loop_d      = loop_q;
        pdm_we_d    = 1'b0;
        pdm_level_d = pdm_level_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tab_d       = tab_q;
        next_idx    = step_q + AW'(1);
        if (cfg_we) begin
            tab_d[cfg_addr] = cfg_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d     = S_PLAY;
                    cnt_d       = '0;
                    step_d      = '0;
                    seq_len_d   = seq_len;
                    loop_d      = loop;
                    pdm_we_d    = 1'b1;
                    pdm_level_d = tab_q[0];
                    busy_d      = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    cnt_d    = '0;
                    step_d   = '0;
                    pdm_we_d = 1'b1;
`ifdef PDM_SEQ_FADE_EN
                    state_d     = S_FADE;
                    pdm_level_d = (pdm_level_q == '0) ? '0 : pdm_level_q - LEVEL_W'(1);
`else
                    state_d     = S_IDLE;
                    pdm_level_d = '0;
                    busy_d      = 1'b0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (step_q < seq_len_q) begin
                        step_d      = next_idx;
                        pdm_we_d    = 1'b1;
                        pdm_level_d = tab_q[next_idx];
                    end else if (loop_q) begin
                        step_d      = '0;
                        pdm_we_d    = 1'b1;
                        pdm_level_d = tab_q[0];
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef PDM_SEQ_FADE_EN
            S_FADE: begin
                // The write of 0 has gone out; release on the following cycle.
                if (pdm_level_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    pdm_we_d    = 1'b1;
                    pdm_level_d = pdm_level_q - LEVEL_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            seq_len_q   <= '0;
            loop_q      <= 1'b0;
            pdm_we_q    <= 1'b0;
            pdm_level_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            seq_len_q   <= seq_len_d;
            loop_q      <= loop_d;
            pdm_we_q    <= pdm_we_d;
            pdm_level_q <= pdm_level_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tab_q       <= tab_d;
        end
    end

    assign pdm_we    = pdm_we_q;
    assign pdm_level = pdm_level_q;
    assign busy      = busy_q;
    assign step_idx  = step_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pdm_level_sequencer.sv
// Scoreboarded bench for pdm_level_sequencer: expected writes/done pulses are queued with
// the edge number at which they must appear and checked every cycle by a monitor.
module tb_pdm_level_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [4:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [2:0] seq_len = '0;
    logic       pdm_we;
    logic [4:0] pdm_level;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    typedef struct {
        int         cyc;
        logic [4:0] lvl;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  edge_cnt = 0;
    int  total = 0;
    int  bad = 0;
    logic exp_we;
    logic exp_done;

    pdm_level_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .seq_len  (seq_len),
        .pdm_we   (pdm_we),
        .pdm_level(pdm_level),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, obs, exp);
        end
    endtask

    // Every cycle the strobes must match the scoreboard head exactly.
    always @(negedge clk) begin
        exp_we   = (wr_q.size() > 0) && (wr_q[0].cyc == edge_cnt);
        exp_done = (done_q.size() > 0) && (done_q[0] == edge_cnt);
        check_output("pdm_we", 32'(pdm_we), 32'(exp_we));
        if (exp_we) begin
            check_output("pdm_level", 32'(pdm_level), 32'(wr_q[0].lvl));
            void'(wr_q.pop_front());
        end
        check_output("done", 32'(done), 32'(exp_done));
        if (exp_done) void'(done_q.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (edge_cnt < c) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [4:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // One-cycle start/stop pulse; n returns the edge that samples it.
    task automatic apply_stimulus(input logic st, input logic sp, input logic lp,
                                  input logic [2:0] sl, output int n);
        n       = edge_cnt + 1;
        start   = st;
        stop    = sp;
        loop    = lp;
        seq_len = sl;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic push_wr(input int c, input logic [4:0] l);
        wr_t w;
        w.cyc = c;
        w.lvl = l;
        wr_q.push_back(w);
    endtask

    initial begin
        int n;
        int n2;
        int idle_at;

        // Reset for two edges, then ten idle cycles of all-zero outputs.
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("idle_zero", 32'({pdm_we, pdm_level, busy, done, step_idx}), 32'(0));
        end

        // Single pass of four entries; loop/seq_len changes after start must not matter.
        cfg_write(3'd0, 5'h08);
        cfg_write(3'd1, 5'h1A);
        cfg_write(3'd2, 5'h0F);
        cfg_write(3'd3, 5'h04);
        n = edge_cnt + 1;
        push_wr(n, 5'h08);
        push_wr(n + 64, 5'h1A);
        push_wr(n + 128, 5'h0F);
        push_wr(n + 192, 5'h04);
        done_q.push_back(n + 256);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd3, n);
        check_output("busy_after_start", 32'(busy), 32'(1));
        check_output("step_after_start", 32'(step_idx), 32'(0));
        loop    = 1'b1;
        seq_len = 3'd7;
        wait_until(n + 70);
        check_output("step_1", 32'(step_idx), 32'(1));
        wait_until(n + 256);
        check_output("busy_at_done", 32'(busy), 32'(0));
        check_output("level_held", 32'(pdm_level), 32'h04);
        wait_until(n + 262);
        check_output("still_idle", 32'(busy), 32'(0));

        // Two-entry loop, then stop while entry 1 plays.
        cfg_write(3'd0, 5'h03);
        cfg_write(3'd1, 5'h05);
        n = edge_cnt + 1;
        push_wr(n, 5'h03);
        push_wr(n + 64, 5'h05);
        push_wr(n + 128, 5'h03);
        push_wr(n + 192, 5'h05);
        apply_stimulus(1'b1, 1'b0, 1'b1, 3'd1, n);
        loop    = 1'b0;
        seq_len = 3'd0;
        wait_until(n + 65);
        check_output("loop_step_a", 32'(step_idx), 32'(1));
        wait_until(n + 129);
        check_output("loop_step_b", 32'(step_idx), 32'(0));
        wait_until(n + 193);
        check_output("loop_step_c", 32'(step_idx), 32'(1));
        wait_until(n + 199);
`ifdef PDM_SEQ_FADE_EN
        for (int k = 0; k < 5; k++) push_wr(n + 200 + 64 * k, 5'(4 - k));
        idle_at = n + 200 + 64 * 4 + 1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 3'd0, n2);
        check_output("fade_busy", 32'(busy), 32'(1));
        wait_until(idle_at - 1);
        check_output("fade_busy_end", 32'(busy), 32'(1));
        wait_until(idle_at);
        check_output("fade_idle", 32'(busy), 32'(0));
`else
        push_wr(n + 200, 5'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 3'd0, n2);
        check_output("mute_busy", 32'(busy), 32'(0));
        check_output("mute_step", 32'(step_idx), 32'(0));
        check_output("mute_level", 32'(pdm_level), 32'(0));
        idle_at = n2;
`endif
        wait_until(idle_at + 70);
        check_output("stopped_idle", 32'(busy), 32'(0));

        // start and stop together in IDLE: stop wins, nothing happens.
        apply_stimulus(1'b1, 1'b1, 1'b0, 3'd3, n);
        check_output("start_stop_busy", 32'(busy), 32'(0));
        wait_until(n + 70);
        check_output("start_stop_idle", 32'(busy), 32'(0));

        // Table rewrites during playback; restart while busy ignored.
        n = edge_cnt + 1;
        push_wr(n, 5'h03);
        push_wr(n + 64, 5'h05);
        push_wr(n + 128, 5'h1F);
        push_wr(n + 192, 5'h04);
        done_q.push_back(n + 256);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd3, n);
        wait_until(n + 9);
        apply_stimulus(1'b1, 1'b0, 1'b1, 3'd1, n2);
        wait_until(n + 99);
        cfg_write(3'd2, 5'h1F);
        wait_until(n + 191);
        cfg_write(3'd3, 5'h11);
        wait_until(n + 258);

        // Next pass sees the entry-3 rewrite.
        n = edge_cnt + 1;
        push_wr(n, 5'h03);
        push_wr(n + 64, 5'h05);
        push_wr(n + 128, 5'h1F);
        push_wr(n + 192, 5'h11);
        done_q.push_back(n + 256);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd3, n);
        wait_until(n + 258);

        // seq_len=0 single shot.
        n = edge_cnt + 1;
        push_wr(n, 5'h03);
        done_q.push_back(n + 64);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, n);
        wait_until(n + 64);
        check_output("single_busy", 32'(busy), 32'(0));
        wait_until(n + 68);

        // Reset mid-play clears everything, table included.
        n = edge_cnt + 1;
        push_wr(n, 5'h03);
        apply_stimulus(1'b1, 1'b0, 1'b1, 3'd3, n);
        wait_until(n + 29);
        reset = 1'b1;
        tick();
        wr_q.delete();
        done_q.delete();
        check_output("reset_zero", 32'({pdm_we, pdm_level, busy, done, step_idx}), 32'(0));
        reset = 1'b0;
        tick();
        n = edge_cnt + 1;
        push_wr(n, 5'h00);
        done_q.push_back(n + 64);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, n);
        check_output("replay_busy", 32'(busy), 32'(1));
        wait_until(n + 66);
        check_output("replay_level", 32'(pdm_level), 32'(0));

        check_output("queues_drained", 32'(wr_q.size() + done_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
